// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and constants for the chunked serial adder.
// The optional subtract mode is enabled with SERIAL_ADD_SUB_EN; nothing here depends on it.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_CHUNK = 4;

  // Width of a counter that must hold values 0..nchunk
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return (nchunk < 1) ? 1 : $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice used by chunked_serial_adder (both with and
// without SERIAL_ADD_SUB_EN); also reports the carry into its MSB for overflow detection.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out without a second adder
  assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock with valid/ready on both sides.
// Define SERIAL_ADD_SUB_EN to add the sub port and turn the block into an adder/subtractor.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic                   w_sub;
  logic [CHUNK-1:0]       w_csum;
  logic                   w_cout;
  logic                   w_cmsb;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]       w_sum_next;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .i_a   (r_a[CHUNK-1:0]),
    .i_b   (r_b[CHUNK-1:0]),
    .i_cin (r_carry),
    .o_sum (w_csum),
    .o_cout(w_cout),
    .o_cmsb(w_cmsb)
  );

  // New chunk enters at the top so the result fills LSB chunk first
  assign w_cat      = {w_csum, r_sum};
  assign w_sum_next = w_cat[WIDTH+CHUNK-1:CHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout      <= w_cout;
            r_ovf       <= w_cout ^ w_cmsb;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder at CHUNK = 1, 4 and 16 (WIDTH = 16).
// Subtract vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_chunked_serial_adder;

  localparam int unsigned W = 16;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  function automatic int unsigned chunk_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
  endfunction

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;

  logic         ir [3];
  logic         ov [3];
  logic         co [3];
  logic         of [3];
  logic [W-1:0] sm [3];

  exp_t q [3][$];
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   rnd_ready = 1'b0;

  logic         seen [3];
  logic         hold [3];
  logic [W+1:0] hval [3];
  logic         mon_busy;
  exp_t         mon_e;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      chunked_serial_adder #(
        .WIDTH(W),
        .CHUNK(chunk_of(g))
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir[g]),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .out_valid(ov[g]),
        .out_ready(out_ready),
        .sum      (sm[g]),
        .cout     (co[g]),
        .ovf      (of[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s chunk=%0d got %h expected %h at cyc %0d", nm, chunk_of(i), act, exp, cyc);
    end
  endtask

  // Reference: plain full-width arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t         e;
    logic [W-1:0] bb;
    int unsigned  total;
    bb    = ms ? ~mb : mb;
    total = int'(ma) + int'(bb) + (ms ? 1 : int'(mc));
    e.s   = total[W-1:0];
    e.c   = total[W];
    e.o   = (ma[W-1] == bb[W-1]) && (e.s[W-1] != ma[W-1]);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: reset values, in_ready, latency, results and hold stability
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk("reset_state", i, 32'({ir[i], ov[i], co[i], of[i], |sm[i]}), 32'h10);
        seen[i] = 1'b0;
        hold[i] = 1'b0;
      end else begin
        mon_busy = 1'b0;
        if (q[i].size() > 0) mon_busy = (cyc >= q[i][0].acc);
        chk("in_ready", i, 32'(ir[i]), 32'(!mon_busy));
        if (hold[i])
          chk("hold_stable", i, 32'({ov[i], co[i], of[i], sm[i]}), 32'({1'b1, hval[i]}));
        if (!mon_busy) begin
          chk("out_valid_idle", i, 32'(ov[i]), 32'd0);
        end else if (ov[i]) begin
          if (!seen[i]) begin
            chk("latency", i, 32'(cyc - q[i][0].acc), 32'(W / chunk_of(i)));
            seen[i] = 1'b1;
          end
          if (out_ready) begin
            mon_e = q[i].pop_front();
            chk("sum", i, 32'(sm[i]), 32'(mon_e.s));
            chk("cout", i, 32'(co[i]), 32'(mon_e.c));
            chk("ovf", i, 32'(of[i]), 32'(mon_e.o));
            seen[i] = 1'b0;
          end
        end
        hold[i] = ov[i] && !out_ready;
        hval[i] = {co[i], of[i], sm[i]};
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2])) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout got busy expected idle at cyc %0d", cyc);
        break;
      end
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic is, input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle();
    a = ia; b = ib; cin = ic; sub = is;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) q[i].push_back('{s: es, c: ec, o: eo, acc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                             input logic is);
    exp_t e;
    e = model(ia, ib, ic, is);
    issue(ia, ib, ic, is, e.s, e.c, e.o);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: results stay put and extra in_valid pulses are ignored
    wait_idle();
    out_ready = 1'b0;
    issue(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 16'hB4B5, 1'b0, 1'b0);
    n = 0;
    while (!(ov[0] && ov[1] && ov[2])) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL valid_timeout got low expected high at cyc %0d", cyc);
        break;
      end
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset two cycles into RUN discards the operation
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) q[i].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    if (HAS_SUB) begin
      issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    end

    rnd_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      issue_model(rnd_operand(), rnd_operand(), 1'($urandom),
                  HAS_SUB ? 1'($urandom) : 1'b0);
    end

    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("drain", i, 32'(q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
